// File: rtl/edge_filter_array.sv
// rtl/edge_filter_array.sv - per-channel synchroniser, glitch filter and qualified edge detector
module edge_filter_array #(
  parameter int   NCH         = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter int   CNT_W       = 8,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NCH-1:0]     d_in,
  input  logic [1:0]         mode,
  input  logic [NCH-1:0]     flag_clr,
  input  logic [NCH-1:0]     cnt_clr,
  output logic [NCH-1:0]     filt_level,
  output logic [NCH-1:0]     edge_pulse,
  output logic [NCH-1:0]     edge_dir,
  output logic [NCH-1:0]     edge_flag,
  output logic [NCH*CNT_W-1:0] edge_cnt
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FC_W-1:0]        r_fc;
    logic                   r_filt;
    logic                   r_prev;
    logic                   r_flag;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s;
    logic                   w_pulse;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], d_in[i]};
      end
    end

    // A level change is accepted only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
      if (!n_rst) begin
        r_fc   <= '0;
        r_filt <= RESET_LEVEL;
        r_prev <= RESET_LEVEL;
      end else begin
        r_prev <= r_filt;
        if (w_s == r_filt) begin
          r_fc <= '0;
        end else if (r_fc == FC_LAST) begin
          r_filt <= w_s;
          r_fc   <= '0;
        end else begin
          r_fc <= r_fc + 1'b1;
        end
      end
    end

    assign w_pulse = (r_filt ^ r_prev) & ((mode[0] & r_filt) | (mode[1] & ~r_filt));

    // Set beats clear on the flag; a clear coinciding with an edge keeps that edge in the count.
    always_ff @(posedge clk) begin
      if (!n_rst) begin
        r_flag <= 1'b0;
        r_cnt  <= '0;
      end else begin
        if (w_pulse) begin
          r_flag <= 1'b1;
        end else if (flag_clr[i]) begin
          r_flag <= 1'b0;
        end
        if (cnt_clr[i]) begin
          r_cnt <= w_pulse ? CNT_W'(1) : '0;
        end else if (w_pulse && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign filt_level[i]                = r_filt;
    assign edge_pulse[i]                = w_pulse;
    assign edge_dir[i]                  = r_filt;
    assign edge_flag[i]                 = r_flag;
    assign edge_cnt[i*CNT_W +: CNT_W]   = r_cnt;
  end

endmodule

// File: tb/tb_edge_filter_array.sv
// tb/tb_edge_filter_array.sv - scoreboard bench for edge_filter_array
module tb_edge_filter_array;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  d_in;
  logic [1:0]  mode;
  logic [3:0]  flag_clr;
  logic [3:0]  cnt_clr;
  logic [3:0]  filt_level;
  logic [3:0]  edge_pulse;
  logic [3:0]  edge_dir;
  logic [3:0]  edge_flag;
  logic [31:0] edge_cnt;

  logic        n_rst_b;
  logic [3:0]  d_in_b;
  logic [3:0]  filt_b;
  logic [3:0]  pulse_b;
  logic [3:0]  dir_b;
  logic [3:0]  flag_b;
  logic [7:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pb_cnt   = 0;

  typedef struct { int ch; bit dir; int cyc; } exp_t;
  exp_t sb[$];

  edge_filter_array u_dut (
    .clk(clk), .n_rst(n_rst), .d_in(d_in), .mode(mode),
    .flag_clr(flag_clr), .cnt_clr(cnt_clr),
    .filt_level(filt_level), .edge_pulse(edge_pulse), .edge_dir(edge_dir),
    .edge_flag(edge_flag), .edge_cnt(edge_cnt)
  );

  edge_filter_array #(.CNT_W(2)) u_dut_b (
    .clk(clk), .n_rst(n_rst_b), .d_in(d_in_b), .mode(2'b11),
    .flag_clr(4'h0), .cnt_clr(4'h0),
    .filt_level(filt_b), .edge_pulse(pulse_b), .edge_dir(dir_b),
    .edge_flag(flag_b), .edge_cnt(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one channel; an accepted transition that the current mode qualifies is expected as a pulse.
  task automatic set_in(input int ch, input logic val, input bit accepted);
    exp_t e;
    d_in[ch] = val;
    if (accepted && ((mode == 2'b11) || (mode == 2'b01 && val) || (mode == 2'b10 && !val))) begin
      e.ch  = ch;
      e.dir = val;
      e.cyc = cyc + SYNC + FILT;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (pulse_b[0]) pb_cnt++;
    for (int ch = 0; ch < 4; ch++) begin
      if (edge_pulse[ch]) begin
        check("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_ch", ch, e.ch);
          check("sb_dir", 32'(edge_dir[ch]), 32'(e.dir));
          check("sb_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; d_in = 4'hF; mode = 2'b11; flag_clr = 4'h0; cnt_clr = 4'h0;
    n_rst_b = 1'b0; d_in_b = 4'hF;
    tick(2);
    check("rst_filt", 32'(filt_level), 32'hF);
    check("rst_flag", 32'(edge_flag), 32'h0);
    check("rst_cnt", edge_cnt, 32'h0);
    check("rst_pulse", 32'(edge_pulse), 32'h0);
    check("rst_dir", 32'(edge_dir), 32'hF);
    n_rst = 1'b1; n_rst_b = 1'b1;
    tick(20);
    check("idle_cnt", edge_cnt, 32'h0);

    // latency and direction on ch0
    set_in(0, 1'b0, 1'b1);
    tick(4);
    check("lat_filt_e3", 32'(filt_level[0]), 32'd1);
    tick(1);
    check("lat_filt_e4", 32'(filt_level[0]), 32'd0);
    check("lat_pulse_e4", 32'(edge_pulse[0]), 32'd1);
    check("lat_dir_e4", 32'(edge_dir[0]), 32'd0);
    check("lat_flag_e4", 32'(edge_flag[0]), 32'd0);
    tick(1);
    check("lat_flag_e5", 32'(edge_flag[0]), 32'd1);
    check("lat_cnt_e5", edge_cnt[7:0], 32'd1);
    check("lat_pulse_e5", 32'(edge_pulse[0]), 32'd0);
    set_in(0, 1'b1, 1'b1);
    tick(8);
    check("lat_cnt_rise", edge_cnt[7:0], 32'd2);

    // glitch rejection on ch1
    set_in(1, 1'b0, 1'b0);
    tick(2);
    set_in(1, 1'b1, 1'b0);
    tick(10);
    check("glitch_filt", 32'(filt_level[1]), 32'd1);
    check("glitch_cnt", edge_cnt[15:8], 32'd0);
    set_in(1, 1'b0, 1'b1);
    tick(3);
    set_in(1, 1'b1, 1'b1);
    tick(10);
    check("accept_cnt", edge_cnt[15:8], 32'd2);

    // mode gating on ch2
    mode = 2'b01;
    tick(1);
    set_in(2, 1'b0, 1'b1);
    tick(6);
    set_in(2, 1'b1, 1'b1);
    tick(8);
    check("rise_cnt", edge_cnt[23:16], 32'd1);
    check("rise_flag", 32'(edge_flag[2]), 32'd1);
    flag_clr[2] = 1'b1;
    tick(1);
    flag_clr[2] = 1'b0;
    mode = 2'b00;
    set_in(2, 1'b0, 1'b1);
    tick(6);
    check("off_filt_lo", 32'(filt_level[2]), 32'd0);
    set_in(2, 1'b1, 1'b1);
    tick(8);
    check("off_filt_hi", 32'(filt_level[2]), 32'd1);
    check("off_flag", 32'(edge_flag[2]), 32'd0);
    check("off_cnt", edge_cnt[23:16], 32'd1);

    // simultaneous clear on ch3
    mode = 2'b11;
    set_in(3, 1'b0, 1'b1);
    tick(8);
    check("pre_clr_cnt", edge_cnt[31:24], 32'd1);
    set_in(3, 1'b1, 1'b1);
    tick(5);
    check("clr_pulse_now", 32'(edge_pulse[3]), 32'd1);
    flag_clr[3] = 1'b1; cnt_clr[3] = 1'b1;
    tick(1);
    flag_clr[3] = 1'b0; cnt_clr[3] = 1'b0;
    check("clr_race_flag", 32'(edge_flag[3]), 32'd1);
    check("clr_race_cnt", edge_cnt[31:24], 32'd1);
    tick(3);
    flag_clr[3] = 1'b1; cnt_clr[3] = 1'b1;
    tick(1);
    flag_clr[3] = 1'b0; cnt_clr[3] = 1'b0;
    check("clr_flag", 32'(edge_flag[3]), 32'd0);
    check("clr_cnt", edge_cnt[31:24], 32'd0);

    // saturation and mid-operation reset, CNT_W = 2
    for (int k = 0; k < 5; k++) begin
      d_in_b[0] = k[0];
      tick(6);
    end
    tick(4);
    check("sat_pulses", pb_cnt, 32'd5);
    check("sat_cnt", 32'(cnt_b[1:0]), 32'd3);
    d_in_b[0] = 1'b1;
    tick(3);
    n_rst_b = 1'b0;
    tick(1);
    check("mrst_cnt", 32'(cnt_b), 32'd0);
    check("mrst_filt", 32'(filt_b), 32'hF);
    check("mrst_flag", 32'(flag_b), 32'd0);
    check("mrst_pulse", 32'(pulse_b), 32'd0);
    n_rst_b = 1'b1;
    tick(10);
    check("mrst_no_pulse", pb_cnt, 32'd5);
    check("mrst_cnt_after", 32'(cnt_b), 32'd0);

    tick(4);
    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_filter_array.md
# edge_filter_array

Parametrised multi-channel edge detector for the bus front end. Each of NCH asynchronous inputs is synchronised, glitch-filtered over FILT_LEN consecutive samples, then edge-detected with a selectable polarity. Per channel, the block emits a one-cycle edge pulse with direction, a sticky edge flag and a saturating edge counter. Downstream decoders (line-state, EOP, bit-stuff) consume the filtered levels and pulses.

## Interface
- NCH, default 4: number of independent channels.
- SYNC_STAGES, default 2: synchroniser depth. Legal range 2..4.
- FILT_LEN, default 3: consecutive differing samples needed to accept a level change. Legal range 1..15; 1 means no filtering.
- CNT_W, default 8: width of each per-channel edge counter.
- RESET_LEVEL, default 1'b1: value loaded into the synchroniser, filtered level and previous level at reset (bus idle).
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous and active-low.
- d_in  in  NCH  raw asynchronous channel inputs.
- mode  in  2  edge qualification, shared by all channels: 00 off, 01 rising, 10 falling, 11 both.
- flag_clr  in  NCH  per-channel sticky flag clear; level-sensitive, one bit per channel.
- cnt_clr  in  NCH  per-channel counter clear.
- filt_level  out  NCH  filtered, synchronised level per channel.
- edge_pulse  out  NCH  one-cycle pulse for each qualified edge.
- edge_dir  out  NCH  direction of the current filtered transition: 1 rising, 0 falling. Valid whenever a filtered transition occurs, independent of mode.
- edge_flag  out  NCH  sticky "qualified edge seen" flag.
- edge_cnt  out  NCH*CNT_W  per-channel counters, flattened; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Synchroniser: a SYNC_STAGES flop chain per channel. Its last stage is s[i].
- Filter, per channel, with counter fc of width clog2(FILT_LEN+1):
  - If s == filt_level: fc <= 0.
  - Otherwise, if fc == FILT_LEN-1: filt_level <= s and fc <= 0.
  - Otherwise: fc <= fc+1.
  - Any return of s to filt_level before acceptance resets fc. Glitches shorter than FILT_LEN samples are fully suppressed.
- Edge detection: prev <= filt_level each cycle.
  - raw_edge = filt_level ^ prev.
  - edge_dir = filt_level.
  - edge_pulse = raw_edge gated by mode: 01 passes only when filt_level is 1; 10 passes only when it is 0; 11 passes both; 00 passes none. The output is combinational from registers.
- Filtering and tracking of filt_level always run; mode affects only edge_pulse, edge_flag and edge_cnt. A mode change takes effect in the same cycle.
- edge_flag: on edge_pulse it is set at the next clock. flag_clr clears it. If both occur in the same cycle, set wins (the flag stays 1).
- edge_cnt: on edge_pulse it increments at the next clock and saturates at 2^CNT_W-1 with no wrap. cnt_clr loads 0. If cnt_clr and edge_pulse occur in the same cycle, the counter loads 1 so the edge is not lost.
- Channels are fully independent, with no cross-channel arbitration.

## Timing
- Reset values:
  - sync chain, filt_level, prev = RESET_LEVEL.
  - fc, edge_flag, edge_cnt = 0.
  - edge_pulse = 0 (prev equals filt_level).
  - edge_dir = RESET_LEVEL.
- Reset mid-operation: all state returns to the reset values at the asserting clock edge. A pending filter count is discarded and no pulse is produced by reset itself.
- Latency: a new stable d_in value sampled at edge 0 changes filt_level at edge SYNC_STAGES+FILT_LEN-1. edge_pulse is high from that edge until the next one (exactly one cycle). edge_flag and edge_cnt update at edge SYNC_STAGES+FILT_LEN. With defaults: filt_level changes at edge 4, the pulse covers cycle 4→5, and flag and count update at edge 5.
- Maximum edge rate per channel: one accepted transition per FILT_LEN cycles. Back-to-back accepted transitions yield distinct pulses, with no pulse merging.
- After reset deassertion, an input sitting at the inverse of RESET_LEVEL is reported as a normal edge after the standard latency.

## Test plan
- Reset and idle: defaults, n_rst low for 2 cycles then high, d_in = 4'hF held.
  - During reset, filt_level = 4'hF and all flags and counters are 0.
  - After release, there is no edge_pulse for 20 cycles.
- Latency and direction: defaults, mode = 11, d_in[0] 1→0 sampled at edge 0.
  - filt_level[0] = 0 at edge 4.
  - edge_pulse[0] high for one cycle with edge_dir[0] = 0.
  - edge_flag[0] = 1 and edge_cnt ch0 = 1 at edge 5.
- Glitch rejection: d_in[1] low for 2 cycles, then high.
  - No change on filt_level[1] and no pulse.
  - A 3-cycle low is accepted: a falling then rising pair gives edge_cnt ch1 = 2 with mode 11.
- Mode gating: mode = 01, toggle d_in[2] low then high (each held 6 cycles).
  - Only the rising edge pulses and the count is 1.
  - Repeat with mode = 00: no pulse, no flag, count unchanged, filt_level still tracks the input.
- Simultaneous clear:
  - flag_clr[3] and cnt_clr[3] asserted in the same cycle as edge_pulse[3] → edge_flag[3] stays 1 and edge_cnt ch3 = 1.
  - Clear with no edge → flag 0, count 0.
- Saturation and mid-operation reset, with CNT_W = 2:
  - 5 qualified edges on ch0 → edge_cnt ch0 = 3.
  - Then n_rst low during an in-progress filter count → all counters 0, no pulse, filt_level = RESET_LEVEL.
